// File: rtl/spi_flash_reader.sv
`default_nettype none
// spi_flash_reader: sequences an spi master's register port to issue a serial-flash READ
// (command, 24-bit address, LEN dummy bytes) and streams the returned data bytes out.
module spi_flash_reader #(
  parameter logic [31:0] SPI_BASE = 32'h0,
  parameter logic [7:0]  CLK_DIV  = 8'd1,
  parameter logic        CPOL     = 1'b0,
  parameter logic        CPHA     = 1'b0,
  parameter logic [7:0]  RD_CMD   = 8'h03,
  parameter int          LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_data_o,
  output logic             m_we_o,
  input  logic [31:0]      m_data_i
);

  localparam logic [31:0] A_CTRL   = SPI_BASE;
  localparam logic [31:0] A_DATA   = SPI_BASE + 32'h4;
  localparam logic [31:0] A_STAT   = SPI_BASE + 32'h8;
  localparam logic [31:0] CTRL_ON  = {16'h0, CLK_DIV, 4'b0, 1'b1, CPHA, CPOL, 1'b1};
  localparam logic [31:0] CTRL_OFF = {16'h0, CLK_DIV, 4'b0, 1'b0, CPHA, CPOL, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DATA, S_KICK, S_GUARD, S_POLL, S_CAPTURE, S_OUT, S_DESEL, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W:0]   idx;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       guard_cnt;
  logic [7:0]       rdata_q;
  logic [7:0]       tx_byte;
  logic             header;
  logic             last;
  logic             unused_m_data;

  assign unused_m_data = ^m_data_i[31:8];

  // idx is one bit wider than len so the final index 3+len never wraps
  assign header = (idx <= (LEN_W+1)'(3));
  assign last   = (idx == ({1'b0, len_q} + (LEN_W+1)'(3)));

  always_comb begin
    tx_byte = 8'h00;
    if (idx == (LEN_W+1)'(0))      tx_byte = RD_CMD;
    else if (idx == (LEN_W+1)'(1)) tx_byte = addr_q[23:16];
    else if (idx == (LEN_W+1)'(2)) tx_byte = addr_q[15:8];
    else if (idx == (LEN_W+1)'(3)) tx_byte = addr_q[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_we_o    = 1'b0;
    m_addr_o  = A_STAT;
    m_data_o  = 32'h0;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        m_we_o    = 1'b1;
        m_addr_o  = A_DATA;
        m_data_o  = {24'h0, tx_byte};
        state_nxt = S_KICK;
      end
      S_KICK: begin
        m_we_o    = 1'b1;
        m_addr_o  = A_CTRL;
        m_data_o  = CTRL_ON;
        state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt == 2'd2) state_nxt = S_POLL;
      end
      S_POLL: begin
        if (!m_data_i[0]) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        m_addr_o = A_DATA;
        if (!header)   state_nxt = S_OUT;
        else if (last) state_nxt = S_DESEL;
        else           state_nxt = S_WR_DATA;
      end
      S_OUT: begin
        // holding here keeps the bus quiet: no SCK activity, slave stays selected
        if (rready_i) state_nxt = last ? S_DESEL : S_WR_DATA;
      end
      S_DESEL: begin
        m_we_o    = 1'b1;
        m_addr_o  = A_CTRL;
        m_data_o  = CTRL_OFF;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      guard_cnt <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= addr_i;
            len_q  <= len_i;
            idx    <= '0;
          end
        end
        S_KICK:  guard_cnt <= '0;
        S_GUARD: guard_cnt <= guard_cnt + 2'd1;
        S_CAPTURE: begin
          if (!header) rdata_q <= m_data_i[7:0];
          else         idx     <= idx + (LEN_W+1)'(1);
        end
        S_OUT: begin
          if (rready_i) idx <= idx + (LEN_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (state != S_IDLE) && (state != S_DONE);
  assign done_o   = (state == S_DONE);
  assign rvalid_o = (state == S_OUT);
  assign rdata_o  = rdata_q;

endmodule
`default_nettype wire
